// File: rtl/ysyx_210544_operand_fetch_if.sv
// ----------------------------------------------------------------------------
// ysyx_210544_operand_fetch_if
//   Bundles every non-clock/reset signal of the operand-fetch stage: the ID
//   capture handshake, the register-file read port, the WB retire/forward
//   port, the flush and the EX handoff handshake.
//   slave  : view of the operand-fetch stage (i_* in, o_* out)
//   master : view of its environment (i_* out, o_* in)
// ----------------------------------------------------------------------------
interface ysyx_210544_operand_fetch_if #(
    parameter int XLEN = 64
);
    logic            i_id_valid;
    logic            o_id_ready;
    logic [4:0]      i_id_rs1;
    logic [4:0]      i_id_rs2;
    logic            i_id_rs1_ren;
    logic            i_id_rs2_ren;
    logic [4:0]      i_id_rd;
    logic            i_id_rd_wen;
    logic [XLEN-1:0] i_id_pc;

    logic [4:0]      o_rs1;
    logic [4:0]      o_rs2;
    logic            o_rs1_ren;
    logic            o_rs2_ren;
    logic [XLEN-1:0] i_rs1_data;
    logic [XLEN-1:0] i_rs2_data;

    logic            i_wb_valid;
    logic [4:0]      i_wb_rd;
    logic [XLEN-1:0] i_wb_data;

    logic            i_flush;

    logic            o_ex_valid;
    logic            i_ex_ready;
    logic [XLEN-1:0] o_ex_rs1_data;
    logic [XLEN-1:0] o_ex_rs2_data;
    logic [4:0]      o_ex_rd;
    logic            o_ex_rd_wen;
    logic [XLEN-1:0] o_ex_pc;

    modport slave (
        input  i_id_valid, i_id_rs1, i_id_rs2, i_id_rs1_ren, i_id_rs2_ren,
               i_id_rd, i_id_rd_wen, i_id_pc,
               i_rs1_data, i_rs2_data,
               i_wb_valid, i_wb_rd, i_wb_data,
               i_flush, i_ex_ready,
        output o_id_ready, o_rs1, o_rs2, o_rs1_ren, o_rs2_ren,
               o_ex_valid, o_ex_rs1_data, o_ex_rs2_data, o_ex_rd, o_ex_rd_wen, o_ex_pc
    );

    modport master (
        output i_id_valid, i_id_rs1, i_id_rs2, i_id_rs1_ren, i_id_rs2_ren,
               i_id_rd, i_id_rd_wen, i_id_pc,
               i_rs1_data, i_rs2_data,
               i_wb_valid, i_wb_rd, i_wb_data,
               i_flush, i_ex_ready,
        input  o_id_ready, o_rs1, o_rs2, o_rs1_ren, o_rs2_ren,
               o_ex_valid, o_ex_rs1_data, o_ex_rs2_data, o_ex_rd, o_ex_rd_wen, o_ex_pc
    );
endinterface

// File: rtl/ysyx_210544_operand_fetch.sv
// ----------------------------------------------------------------------------
// ysyx_210544_operand_fetch
//   Read-side requester for the 32x64 register file, between ID and EX.
//   Drives rs1/rs2 read indices, blocks RAW hazards with a per-register
//   pending-write counter, forwards the value WB is retiring this cycle and
//   hands registered operands to EX over valid/ready.
// Ports
//   clk  : clock, all state on the rising edge
//   rst  : asynchronous reset, active low
//   bus  : ysyx_210544_operand_fetch_if.slave (ID, regfile, WB, flush, EX)
// ----------------------------------------------------------------------------
module ysyx_210544_operand_fetch #(
    parameter int XLEN     = 64,
    parameter int SB_CNT_W = 2
) (
    input  logic                           clk,
    input  logic                           rst,
    ysyx_210544_operand_fetch_if.slave     bus
);
    typedef logic [SB_CNT_W-1:0] cnt_t;
    typedef logic [SB_CNT_W:0]   cnt_sum_t;

    localparam cnt_sum_t CNT_MAX = cnt_sum_t'((1 << SB_CNT_W) - 1);

    logic            ex_valid_q,   ex_valid_d;
    logic [XLEN-1:0] ex_rs1_q,     ex_rs1_d;
    logic [XLEN-1:0] ex_rs2_q,     ex_rs2_d;
    logic [4:0]      ex_rd_q,      ex_rd_d;
    logic            ex_rd_wen_q,  ex_rd_wen_d;
    logic [XLEN-1:0] ex_pc_q,      ex_pc_d;
    cnt_t            cnt_q [32];
    cnt_t            cnt_d [32];

    logic [4:0]      src_rs    [2];
    logic            src_ren   [2];
    logic [XLEN-1:0] src_rdata [2];
    logic            src_used  [2];
    logic            src_held  [2];
    logic            src_wb    [2];
    logic            src_busy  [2];
    logic            src_fwd   [2];
    logic [XLEN-1:0] src_op    [2];

    logic            dst_held;
    cnt_sum_t        dst_pending;
    logic            dst_stall;
    logic            stall;
    logic            id_ready;
    logic            capture;
    logic            handoff;
    logic [31:0]     sb_inc;
    logic [31:0]     sb_dec;

    assign bus.o_rs1     = bus.i_id_rs1;
    assign bus.o_rs2     = bus.i_id_rs2;
    assign bus.o_rs1_ren = bus.i_id_valid & bus.i_id_rs1_ren;
    assign bus.o_rs2_ren = bus.i_id_valid & bus.i_id_rs2_ren;

    always_comb begin
        src_rs[0]    = bus.i_id_rs1;
        src_rs[1]    = bus.i_id_rs2;
        src_ren[0]   = bus.i_id_rs1_ren;
        src_ren[1]   = bus.i_id_rs2_ren;
        src_rdata[0] = bus.i_rs1_data;
        src_rdata[1] = bus.i_rs2_data;
    end

    // A source is safe when nothing older than WB-this-cycle still owes it a
    // write: the held instruction must not write it, and at most the one
    // outstanding write may exist, retiring right now (then it is forwarded).
    always_comb begin
        for (int s = 0; s < 2; s++) begin
            src_used[s] = src_ren[s] & (src_rs[s] != 5'd0);
            src_held[s] = ex_valid_q & ex_rd_wen_q & (ex_rd_q == src_rs[s]);
            src_wb[s]   = bus.i_wb_valid & (bus.i_wb_rd == src_rs[s]);
            src_busy[s] = src_used[s] &
                          (src_held[s] |
                           (cnt_q[src_rs[s]] > cnt_t'(1)) |
                           ((cnt_q[src_rs[s]] == cnt_t'(1)) & ~src_wb[s]));
            src_fwd[s]  = src_used[s] & (cnt_q[src_rs[s]] == cnt_t'(1)) &
                          src_wb[s] & ~src_held[s];
            if (!src_used[s]) begin
                src_op[s] = '0;
            end else if (src_fwd[s]) begin
                src_op[s] = bus.i_wb_data;
            end else begin
                src_op[s] = src_rdata[s];
            end
        end
    end

    // The held writer will be counted when it hands off, so it occupies a
    // slot already; a same-cycle WB does not free one until the next cycle.
    always_comb begin
        dst_held    = ex_valid_q & ex_rd_wen_q & (ex_rd_q == bus.i_id_rd);
        dst_pending = cnt_sum_t'(cnt_q[bus.i_id_rd]) + cnt_sum_t'(dst_held);
        dst_stall   = bus.i_id_rd_wen & (bus.i_id_rd != 5'd0) & (dst_pending >= CNT_MAX);
        stall       = src_busy[0] | src_busy[1] | dst_stall;
        id_ready    = rst & ~bus.i_flush & ~stall & (~ex_valid_q | bus.i_ex_ready);
        capture     = bus.i_id_valid & id_ready;
        handoff     = ex_valid_q & bus.i_ex_ready & ~bus.i_flush;
    end

    assign bus.o_id_ready = id_ready;

    always_comb begin
        ex_valid_d  = ex_valid_q;
        ex_rs1_d    = ex_rs1_q;
        ex_rs2_d    = ex_rs2_q;
        ex_rd_d     = ex_rd_q;
        ex_rd_wen_d = ex_rd_wen_q;
        ex_pc_d     = ex_pc_q;
        if (capture) begin
            ex_valid_d  = 1'b1;
            ex_rs1_d    = src_op[0];
            ex_rs2_d    = src_op[1];
            ex_rd_d     = bus.i_id_rd;
            ex_rd_wen_d = bus.i_id_rd_wen;
            ex_pc_d     = bus.i_id_pc;
        end else if (handoff || bus.i_flush) begin
            ex_valid_d  = 1'b0;
        end
    end

    always_comb begin
        sb_inc = '0;
        sb_dec = '0;
        if (handoff && ex_rd_wen_q) begin
            sb_inc[ex_rd_q] = 1'b1;
        end
        if (bus.i_wb_valid) begin
            sb_dec[bus.i_wb_rd] = 1'b1;
        end
        sb_inc[0] = 1'b0;
        sb_dec[0] = 1'b0;
    end

    // A decrement at zero is an upstream protocol error; the counter holds 0.
    always_comb begin
        for (int r = 0; r < 32; r++) begin
            cnt_d[r] = cnt_q[r];
            if (sb_inc[r] && !sb_dec[r]) begin
                cnt_d[r] = cnt_q[r] + cnt_t'(1);
            end else if (sb_dec[r] && !sb_inc[r] && (cnt_q[r] != '0)) begin
                cnt_d[r] = cnt_q[r] - cnt_t'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ex_valid_q  <= 1'b0;
            ex_rs1_q    <= '0;
            ex_rs2_q    <= '0;
            ex_rd_q     <= '0;
            ex_rd_wen_q <= 1'b0;
            ex_pc_q     <= '0;
            for (int r = 0; r < 32; r++) begin
                cnt_q[r] <= '0;
            end
        end else begin
            ex_valid_q  <= ex_valid_d;
            ex_rs1_q    <= ex_rs1_d;
            ex_rs2_q    <= ex_rs2_d;
            ex_rd_q     <= ex_rd_d;
            ex_rd_wen_q <= ex_rd_wen_d;
            ex_pc_q     <= ex_pc_d;
            for (int r = 0; r < 32; r++) begin
                cnt_q[r] <= cnt_d[r];
            end
        end
    end

    assign bus.o_ex_valid    = ex_valid_q;
    assign bus.o_ex_rs1_data = ex_rs1_q;
    assign bus.o_ex_rs2_data = ex_rs2_q;
    assign bus.o_ex_rd       = ex_rd_q;
    assign bus.o_ex_rd_wen   = ex_rd_wen_q;
    assign bus.o_ex_pc       = ex_pc_q;
endmodule

// File: tb/tb_ysyx_210544_operand_fetch.sv
module tb_ysyx_210544_operand_fetch;
    localparam int XLEN = 64;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    ysyx_210544_operand_fetch_if #(.XLEN(XLEN)) bus();

    ysyx_210544_operand_fetch #(.XLEN(XLEN), .SB_CNT_W(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    // Reference model: architectural register values, number of handed-off
    // writes not yet retired per register, and the instruction waiting for EX.
    logic [63:0] rf [32];
    int          pend [32];
    bit          h_valid;
    bit          h_wen;
    logic [4:0]  h_rd;
    logic [63:0] h_rs1, h_rs2, h_pc;

    int vectors = 0;
    int miscompares = 0;

    assign bus.i_rs1_data = rf[bus.i_id_rs1];
    assign bus.i_rs2_data = rf[bus.i_id_rs2];

    function automatic bit held_writes(logic [4:0] r);
        return h_valid && h_wen && (h_rd == r) && (r != 5'd0);
    endfunction

    // A source must wait while any write to it remains outstanding once this
    // cycle's WB (if any) has retired.
    function automatic bit m_busy(logic ren, logic [4:0] rs);
        int left;
        if (!ren || rs == 5'd0) return 1'b0;
        left = pend[rs] - ((bus.i_wb_valid && bus.i_wb_rd == rs) ? 1 : 0);
        return held_writes(rs) || (left > 0);
    endfunction

    function automatic logic [63:0] m_val(logic ren, logic [4:0] rs);
        if (!ren || rs == 5'd0) return 64'd0;
        if (bus.i_wb_valid && bus.i_wb_rd == rs) return bus.i_wb_data;
        return rf[rs];
    endfunction

    function automatic bit m_ready();
        bit dstall;
        dstall = bus.i_id_rd_wen && (bus.i_id_rd != 5'd0) &&
                 (pend[bus.i_id_rd] + (held_writes(bus.i_id_rd) ? 1 : 0) >= 3);
        return rst && !bus.i_flush && !dstall &&
               !m_busy(bus.i_id_rs1_ren, bus.i_id_rs1) &&
               !m_busy(bus.i_id_rs2_ren, bus.i_id_rs2) &&
               (!h_valid || bus.i_ex_ready);
    endfunction

    function automatic logic [199:0] dut_vec();
        return {bus.o_id_ready, bus.o_ex_valid, bus.o_ex_rd, bus.o_ex_rd_wen,
                bus.o_ex_pc, bus.o_ex_rs1_data, bus.o_ex_rs2_data};
    endfunction

    function automatic logic [199:0] exp_vec();
        return {m_ready(), h_valid, h_rd, h_wen, h_pc, h_rs1, h_rs2};
    endfunction

    task automatic m_reset();
        h_valid = 0; h_wen = 0; h_rd = '0; h_rs1 = '0; h_rs2 = '0; h_pc = '0;
        for (int i = 0; i < 32; i++) pend[i] = 0;
    endtask

    task automatic rf_init();
        for (int i = 0; i < 32; i++) rf[i] = {$urandom, $urandom};
        rf[0] = 64'hDEAD;
    endtask

    task automatic idle();
        bus.i_id_valid = 0; bus.i_id_rs1 = '0; bus.i_id_rs2 = '0;
        bus.i_id_rs1_ren = 0; bus.i_id_rs2_ren = 0; bus.i_id_rd = '0;
        bus.i_id_rd_wen = 0; bus.i_id_pc = '0; bus.i_wb_valid = 0;
        bus.i_wb_rd = '0; bus.i_wb_data = '0; bus.i_flush = 0; bus.i_ex_ready = 0;
    endtask

    task automatic set_instr(input bit v, input logic [4:0] rs1, input bit r1en,
                             input logic [4:0] rs2, input bit r2en,
                             input logic [4:0] rd, input bit wen, input logic [63:0] pc);
        bus.i_id_valid = v; bus.i_id_rs1 = rs1; bus.i_id_rs1_ren = r1en;
        bus.i_id_rs2 = rs2; bus.i_id_rs2_ren = r2en; bus.i_id_rd = rd;
        bus.i_id_rd_wen = wen; bus.i_id_pc = pc;
    endtask

    // Advance one clock edge, updating the model from the inputs applied.
    task automatic tick();
        bit cap, ho;
        logic [63:0] v1, v2;
        cap = bus.i_id_valid && m_ready();
        ho  = h_valid && bus.i_ex_ready && !bus.i_flush;
        v1  = m_val(bus.i_id_rs1_ren, bus.i_id_rs1);
        v2  = m_val(bus.i_id_rs2_ren, bus.i_id_rs2);
        @(posedge clk);
        if (!rst) begin
            m_reset();
        end else begin
            if (bus.i_wb_valid && bus.i_wb_rd != 5'd0 && pend[bus.i_wb_rd] == 0 &&
                !(ho && h_wen && h_rd == bus.i_wb_rd))
                $error("bench drove WB to a register with no outstanding write");
            if (ho && h_wen && h_rd != 5'd0) pend[h_rd]++;
            if (bus.i_wb_valid && bus.i_wb_rd != 5'd0) begin
                pend[bus.i_wb_rd]--;
                rf[bus.i_wb_rd] = bus.i_wb_data;
            end
            if (cap) begin
                h_valid = 1; h_rs1 = v1; h_rs2 = v2; h_rd = bus.i_id_rd;
                h_wen = bus.i_id_rd_wen; h_pc = bus.i_id_pc;
            end else if (ho || bus.i_flush) begin
                h_valid = 0;
            end
        end
        #1;
    endtask

    task automatic do_reset();
        rst = 0;
        idle();
        m_reset();
        tick();
        tick();
        rst = 1;
        rf_init();
    endtask

    task automatic test_reset();
        rf_init();
        rst = 0;
        idle();
        set_instr(1, 5'd0, 1, 5'd0, 0, 5'd1, 1, 64'h100);
        m_reset();
        #1;
        vectors++;
        if (dut_vec() !== 200'd0) begin
            miscompares++;
            $display("FAIL reset_outputs got %h want %h", dut_vec(), 200'd0);
        end
        tick();
        tick();
        vectors++;
        if (bus.o_ex_valid !== 1'b0 || bus.o_id_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_hold ex_valid=%b id_ready=%b want 0 0", bus.o_ex_valid, bus.o_id_ready);
        end
        rst = 1;
        #1;
        vectors++;
        if (bus.o_id_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL release_ready got %b want 1", bus.o_id_ready);
        end
        tick();
        vectors++;
        if ({bus.o_ex_valid, bus.o_ex_rd, bus.o_ex_pc, bus.o_ex_rs1_data} !== {1'b1, 5'd1, 64'h100, 64'd0}) begin
            miscompares++;
            $display("FAIL release_capture got v=%b rd=%0d pc=%h rs1=%h want 1 1 100 0",
                     bus.o_ex_valid, bus.o_ex_rd, bus.o_ex_pc, bus.o_ex_rs1_data);
        end
    endtask

    task automatic test_independent();
        do_reset();
        bus.i_ex_ready = 1;
        for (int i = 0; i < 4; i++) begin
            set_instr(1, (i == 0) ? 5'd0 : 5'(8 + i), 1, 5'(12 + i), 1, 5'(1 + i), 1, 64'h200 + 64'(4 * i));
            #1;
            vectors++;
            if (bus.o_id_ready !== 1'b1 || dut_vec() !== exp_vec()) begin
                miscompares++;
                $display("FAIL indep_issue%0d got %h want %h", i, dut_vec(), exp_vec());
            end
            tick();
            vectors++;
            if ({bus.o_ex_valid, bus.o_ex_rs1_data, bus.o_ex_rs2_data} !==
                {1'b1, (i == 0) ? 64'd0 : rf[8 + i], rf[12 + i]}) begin
                miscompares++;
                $display("FAIL indep_operands%0d got v=%b %h %h", i, bus.o_ex_valid, bus.o_ex_rs1_data, bus.o_ex_rs2_data);
            end
        end
        set_instr(0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        vectors++;
        if (bus.o_ex_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL indep_drain got %b want 0", bus.o_ex_valid);
        end
    endtask

    task automatic test_raw_forward();
        bit exr [5] = '{0, 0, 1, 1, 1};
        bit wbv [5] = '{0, 0, 0, 0, 1};
        bit rdy [5] = '{0, 0, 0, 0, 1};
        do_reset();
        set_instr(1, 5'd0, 0, 5'd0, 0, 5'd5, 1, 64'h300);
        tick();
        set_instr(1, 5'd5, 1, 5'd0, 0, 5'd6, 1, 64'h304);
        for (int s = 0; s < 5; s++) begin
            bus.i_ex_ready = exr[s];
            bus.i_wb_valid = wbv[s];
            bus.i_wb_rd    = wbv[s] ? 5'd5 : 5'd0;
            bus.i_wb_data  = 64'h1234;
            #1;
            vectors++;
            if (bus.o_id_ready !== rdy[s] || dut_vec() !== exp_vec()) begin
                miscompares++;
                $display("FAIL raw_step%0d ready=%b want %b got %h want %h", s, bus.o_id_ready, rdy[s], dut_vec(), exp_vec());
            end
            tick();
        end
        idle();
        vectors++;
        if ({bus.o_ex_valid, bus.o_ex_pc, bus.o_ex_rs1_data} !== {1'b1, 64'h304, 64'h1234}) begin
            miscompares++;
            $display("FAIL raw_forward got v=%b pc=%h rs1=%h want 1 304 1234", bus.o_ex_valid, bus.o_ex_pc, bus.o_ex_rs1_data);
        end
    endtask

    task automatic test_saturation();
        bit wbv [10] = '{0, 0, 0, 0, 0, 1, 0, 1, 0, 0};
        bit exr [10] = '{1, 1, 1, 1, 1, 1, 1, 1, 0, 0};
        bit rdy [10] = '{1, 1, 1, 0, 0, 0, 1, 0, 1, 0};
        do_reset();
        for (int s = 0; s < 10; s++) begin
            set_instr(1, 5'd0, 0, 5'd0, 0, 5'd7, 1, 64'h400 + 64'(s));
            bus.i_ex_ready = exr[s];
            bus.i_wb_valid = wbv[s];
            bus.i_wb_rd    = wbv[s] ? 5'd7 : 5'd0;
            bus.i_wb_data  = {$urandom, $urandom};
            #1;
            vectors++;
            if (bus.o_id_ready !== rdy[s] || dut_vec() !== exp_vec()) begin
                miscompares++;
                $display("FAIL sat_step%0d ready=%b want %b got %h want %h", s, bus.o_id_ready, rdy[s], dut_vec(), exp_vec());
            end
            tick();
        end
        idle();
    endtask

    task automatic test_flush();
        do_reset();
        set_instr(1, 5'd0, 0, 5'd0, 0, 5'd9, 1, 64'h500);
        tick();
        set_instr(1, 5'd9, 1, 5'd0, 0, 5'd10, 1, 64'h504);
        bus.i_flush = 1;
        #1;
        vectors++;
        if ({bus.o_ex_valid, bus.o_id_ready} !== 2'b10) begin
            miscompares++;
            $display("FAIL flush_cycle ex_valid=%b id_ready=%b want 1 0", bus.o_ex_valid, bus.o_id_ready);
        end
        tick();
        bus.i_flush = 0;
        #1;
        vectors++;
        if ({bus.o_ex_valid, bus.o_id_ready} !== 2'b01 || dut_vec() !== exp_vec()) begin
            miscompares++;
            $display("FAIL flush_after got %h want %h", dut_vec(), exp_vec());
        end
        tick();
        vectors++;
        if ({bus.o_ex_valid, bus.o_ex_pc, bus.o_ex_rs1_data} !== {1'b1, 64'h504, rf[9]}) begin
            miscompares++;
            $display("FAIL flush_recapture got v=%b pc=%h rs1=%h", bus.o_ex_valid, bus.o_ex_pc, bus.o_ex_rs1_data);
        end
        idle();
    endtask

    task automatic test_async_reset();
        do_reset();
        set_instr(1, 5'd0, 0, 5'd0, 0, 5'd3, 1, 64'h600);
        tick();
        set_instr(1, 5'd3, 1, 5'd0, 0, 5'd4, 1, 64'h604);
        #1;
        vectors++;
        if ({bus.o_ex_valid, bus.o_id_ready} !== 2'b10) begin
            miscompares++;
            $display("FAIL areset_stall ex_valid=%b id_ready=%b want 1 0", bus.o_ex_valid, bus.o_id_ready);
        end
        @(negedge clk);
        rst = 0;
        #1;
        vectors++;
        if (dut_vec() !== 200'd0) begin
            miscompares++;
            $display("FAIL areset_immediate got %h want 0", dut_vec());
        end
        m_reset();
        tick();
        rst = 1;
        idle();
    endtask

    task automatic test_random();
        int cands[$];
        logic [4:0] rs1, rs2;
        bit v, r1en, r2en;
        do_reset();
        for (int n = 0; n < 2000; n++) begin
            v = ($urandom_range(0, 3) != 0);
            rs1 = 5'($urandom_range(0, 7)); r1en = $urandom_range(0, 1);
            rs2 = 5'($urandom_range(0, 7)); r2en = $urandom_range(0, 1);
            set_instr(v, rs1, r1en, rs2, r2en, 5'($urandom_range(0, 7)), $urandom_range(0, 1),
                      {$urandom, $urandom});
            bus.i_ex_ready = ($urandom_range(0, 9) < 7);
            bus.i_flush    = ($urandom_range(0, 15) == 0);
            cands.delete();
            for (int r = 1; r < 32; r++) if (pend[r] > 0) cands.push_back(r);
            bus.i_wb_valid = (cands.size() > 0) && ($urandom_range(0, 9) < 6);
            bus.i_wb_rd    = bus.i_wb_valid ? 5'(cands[$urandom_range(0, cands.size() - 1)]) : 5'd0;
            bus.i_wb_data  = {$urandom, $urandom};
            #1;
            vectors++;
            if (dut_vec() !== exp_vec()) begin
                miscompares++;
                $display("FAIL random%0d got %h want %h", n, dut_vec(), exp_vec());
            end
            vectors++;
            if ({bus.o_rs1, bus.o_rs2, bus.o_rs1_ren, bus.o_rs2_ren} !== {rs1, rs2, v & r1en, v & r2en}) begin
                miscompares++;
                $display("FAIL random_rdport%0d got %0d %0d %b %b want %0d %0d %b %b", n,
                         bus.o_rs1, bus.o_rs2, bus.o_rs1_ren, bus.o_rs2_ren, rs1, rs2, v & r1en, v & r2en);
            end
            tick();
        end
        idle();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        idle();
        m_reset();
        #2;
        test_reset();
        test_independent();
        test_raw_forward();
        test_saturation();
        test_flush();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
